// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared constants, state/source encodings and helpers for the
// memory controller (size encodings, I/O port base, zero word).
package mem_ctrl_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int unsigned DATA_TYPE = 32;

  // Byte counts carried on the *_size request fields
  localparam logic [2:0] SIZE_B = 3'd1;
  localparam logic [2:0] SIZE_H = 3'd2;
  localparam logic [2:0] SIZE_W = 3'd4;

  localparam logic [DATA_TYPE-1:0] RAM_IO_PORT = 32'h0003_0000;
  localparam logic [DATA_TYPE-1:0] ZERO_WORD   = '0;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;
  typedef enum logic [1:0] {SRC_FETCH, SRC_LSB, SRC_ROB} src_e;

  // One pending request slot per source
  typedef struct packed {
    logic                 vld;
    logic [DATA_TYPE-1:0] addr;
    logic [2:0]           n;
    logic                 sgn;
  } req_t;

  // True when addr falls in the 8-byte I/O window starting at base
  function automatic logic in_io_window(input logic [DATA_TYPE-1:0] addr,
                                        input logic [DATA_TYPE-1:0] base);
    return (addr - base) < 32'd8;
  endfunction

  // Sign- or zero-extend an assembled load word according to its byte count
  function automatic logic [DATA_TYPE-1:0] extend_load(input logic [DATA_TYPE-1:0] w,
                                                        input logic [2:0] n,
                                                        input logic sgn);
    case (n)
      SIZE_B:  return {{24{sgn & w[7]}}, w[7:0]};
      SIZE_H:  return {{16{sgn & w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: requester handshakes (fetcher, LSB, ROB) and the byte-wide RAM
// port. slave = controller side, master = requesters/RAM side.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic                 in_fetcher_flag;
  logic [DATA_TYPE-1:0] in_fetcher_addr;
  logic                 out_fetcher_flag;
  logic [DATA_TYPE-1:0] out_fetcher_data;

  logic                 in_lsb_flag;
  logic [DATA_TYPE-1:0] in_lsb_addr;
  logic [5:0]           in_lsb_size;
  logic                 in_lsb_signed;
  logic                 out_lsb_flag;
  logic [DATA_TYPE-1:0] out_lsb_data;

  logic                 in_rob_flag;
  logic [DATA_TYPE-1:0] in_rob_addr;
  logic [5:0]           in_rob_size;
  logic [DATA_TYPE-1:0] in_rob_data;
  logic                 out_rob_flag;
  logic                 in_rob_xbp;

  logic [7:0]           mem_din;
  logic [7:0]           mem_dout;
  logic [DATA_TYPE-1:0] mem_a;
  logic                 mem_wr;
  logic                 io_buffer_full;

  modport slave (
    input  in_fetcher_flag, in_fetcher_addr,
    input  in_lsb_flag, in_lsb_addr, in_lsb_size, in_lsb_signed,
    input  in_rob_flag, in_rob_addr, in_rob_size, in_rob_data, in_rob_xbp,
    input  mem_din, io_buffer_full,
    output out_fetcher_flag, out_fetcher_data,
    output out_lsb_flag, out_lsb_data,
    output out_rob_flag,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output in_fetcher_flag, in_fetcher_addr,
    output in_lsb_flag, in_lsb_addr, in_lsb_size, in_lsb_signed,
    output in_rob_flag, in_rob_addr, in_rob_size, in_rob_data, in_rob_xbp,
    output mem_din, io_buffer_full,
    input  out_fetcher_flag, out_fetcher_data,
    input  out_lsb_flag, out_lsb_data,
    input  out_rob_flag,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl_arb.sv
// mem_ctrl_arb: fixed-priority selector, ROB store > LSB load > fetch.
// gnt_o is one-hot: [2] rob, [1] lsb, [0] fetch.
module mem_ctrl_arb (
  input  logic       fetch_req_i,
  input  logic       lsb_req_i,
  input  logic       rob_req_i,
  output logic [2:0] gnt_o
);
  // Highest-priority active request wins
  always_comb begin
    gnt_o = '0;
    if (rob_req_i)        gnt_o[2] = 1'b1;
    else if (lsb_req_i)   gnt_o[1] = 1'b1;
    else if (fetch_req_i) gnt_o[0] = 1'b1;
  end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: shares the byte-wide RAM port among fetcher, LSB and ROB.
// Latches request pulses, arbitrates, serialises accesses into bytes,
// assembles/extends read data and returns one-cycle done pulses.
// Optional: define MEM_CTRL_IO_STALL_EN to stall I/O-window writes while
// io_buffer_full is high.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_PORT_ADDR = RAM_IO_PORT
) (
  input logic       clk,
  input logic       rst,
  input logic       rdy,
  mem_ctrl_if.slave bus
);

  state_e               state_q;
  src_e                 owner_q;
  req_t                 pf_q, pl_q, pr_q;
  req_t                 pf_d, pl_d, pr_d;
  req_t                 ef, el, er;
  logic [DATA_TYPE-1:0] pr_data_q, er_data;
  logic [DATA_TYPE-1:0] base_q, wdata_q, asm_q, asm_d, rdata;
  logic [2:0]           n_q, cnt_q, cnt_nx;
  logic [1:0]           cap_idx;
  logic                 sgn_q;
  logic [DATA_TYPE-1:0] mem_a_q;
  logic [7:0]           mem_dout_q;
  logic                 mem_wr_q;
  logic                 of_flag_q, ol_flag_q, or_flag_q;
  logic [DATA_TYPE-1:0] of_data_q, ol_data_q;
  logic [2:0]           gnt;
  logic                 idle, flush, stall, rd_done, last_w;
  logic                 f_busy, l_busy, r_busy;
  logic                 unused_bits;

  assign idle    = (state_q == IDLE);
  assign flush   = bus.in_rob_xbp;
  assign cnt_nx  = cnt_q + 3'd1;
  assign cap_idx = 2'(cnt_q - 3'd1);

`ifdef MEM_CTRL_IO_STALL_EN
  assign stall = (state_q == WRITE) && bus.io_buffer_full
                 && in_io_window(mem_a_q, IO_PORT_ADDR);
  assign unused_bits = ^{bus.in_lsb_size[5:3], bus.in_rob_size[5:3]};
`else
  assign stall = 1'b0;
  assign unused_bits = ^{bus.in_lsb_size[5:3], bus.in_rob_size[5:3],
                         bus.io_buffer_full, IO_PORT_ADDR};
`endif

  assign rd_done = (state_q == READ) && (cnt_q == n_q);
  assign last_w  = (state_q == WRITE) && (cnt_nx == n_q) && !stall;

  // A source in service frees its slot at its completion edge
  assign f_busy = pf_q.vld || ((state_q == READ) && (owner_q == SRC_FETCH) && !rd_done);
  assign l_busy = pl_q.vld || ((state_q == READ) && (owner_q == SRC_LSB) && !rd_done);
  assign r_busy = pr_q.vld || ((state_q == WRITE) && !last_w);

  // Merge pending slots with same-edge pulses; flush drops speculative reads
  always_comb begin
    ef = pf_q;
    if (!f_busy && bus.in_fetcher_flag) begin
      ef.vld  = TRUE;
      ef.addr = bus.in_fetcher_addr;
      ef.n    = SIZE_W;
      ef.sgn  = FALSE;
    end
    if (flush) ef.vld = FALSE;

    el = pl_q;
    if (!l_busy && bus.in_lsb_flag) begin
      el.vld  = TRUE;
      el.addr = bus.in_lsb_addr;
      el.n    = bus.in_lsb_size[2:0];
      el.sgn  = bus.in_lsb_signed;
    end
    if (flush) el.vld = FALSE;

    er      = pr_q;
    er_data = pr_data_q;
    if (!r_busy && bus.in_rob_flag) begin
      er.vld  = TRUE;
      er.addr = bus.in_rob_addr;
      er.n    = bus.in_rob_size[2:0];
      er.sgn  = FALSE;
      er_data = bus.in_rob_data;
    end

    pf_d = ef;
    pl_d = el;
    pr_d = er;
    if (gnt[0]) pf_d.vld = FALSE;
    if (gnt[1]) pl_d.vld = FALSE;
    if (gnt[2]) pr_d.vld = FALSE;
  end

  mem_ctrl_arb u_arb (
    .fetch_req_i (idle && ef.vld),
    .lsb_req_i   (idle && el.vld),
    .rob_req_i   (idle && er.vld),
    .gnt_o       (gnt)
  );

  // Byte arriving now lands in lane cnt-1; the final word includes it directly
  always_comb begin
    asm_d = asm_q;
    asm_d[{cap_idx, 3'b000} +: 8] = bus.mem_din;
    rdata = extend_load(asm_d, n_q, sgn_q);
  end

  // Controller FSM, pending slots and registered bus/result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= SRC_FETCH;
      pf_q       <= '0;
      pl_q       <= '0;
      pr_q       <= '0;
      pr_data_q  <= ZERO_WORD;
      base_q     <= ZERO_WORD;
      wdata_q    <= ZERO_WORD;
      asm_q      <= ZERO_WORD;
      n_q        <= '0;
      cnt_q      <= '0;
      sgn_q      <= FALSE;
      mem_a_q    <= ZERO_WORD;
      mem_dout_q <= '0;
      mem_wr_q   <= FALSE;
      of_flag_q  <= FALSE;
      ol_flag_q  <= FALSE;
      or_flag_q  <= FALSE;
      of_data_q  <= ZERO_WORD;
      ol_data_q  <= ZERO_WORD;
    end else if (rdy) begin
      pf_q      <= pf_d;
      pl_q      <= pl_d;
      pr_q      <= pr_d;
      pr_data_q <= er_data;
      of_flag_q <= FALSE;
      ol_flag_q <= FALSE;
      or_flag_q <= FALSE;
      case (state_q)
        IDLE: begin
          if (gnt[2]) begin
            state_q    <= WRITE;
            owner_q    <= SRC_ROB;
            base_q     <= er.addr;
            n_q        <= er.n;
            sgn_q      <= er.sgn;
            wdata_q    <= er_data;
            cnt_q      <= '0;
            mem_a_q    <= er.addr;
            mem_dout_q <= er_data[7:0];
            mem_wr_q   <= TRUE;
          end else if (gnt[1] || gnt[0]) begin
            state_q  <= READ;
            owner_q  <= gnt[1] ? SRC_LSB : SRC_FETCH;
            base_q   <= gnt[1] ? el.addr : ef.addr;
            n_q      <= gnt[1] ? el.n : ef.n;
            sgn_q    <= gnt[1] ? el.sgn : ef.sgn;
            cnt_q    <= '0;
            mem_a_q  <= gnt[1] ? el.addr : ef.addr;
            mem_wr_q <= FALSE;
          end
        end
        READ: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            if (cnt_q != 3'd0) asm_q <= asm_d;
            if (rd_done) begin
              state_q <= IDLE;
              if (owner_q == SRC_LSB) begin
                ol_flag_q <= TRUE;
                ol_data_q <= rdata;
              end else begin
                of_flag_q <= TRUE;
                of_data_q <= rdata;
              end
            end else begin
              cnt_q <= cnt_nx;
              if (cnt_nx < n_q) mem_a_q <= base_q + {29'b0, cnt_nx};
            end
          end
        end
        WRITE: begin
          if (last_w) begin
            state_q   <= IDLE;
            mem_wr_q  <= FALSE;
            or_flag_q <= TRUE;
          end else if (!stall) begin
            cnt_q      <= cnt_nx;
            mem_a_q    <= base_q + {29'b0, cnt_nx};
            mem_dout_q <= wdata_q[{cnt_nx[1:0], 3'b000} +: 8];
            mem_wr_q   <= TRUE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_a            = mem_a_q;
  assign bus.mem_dout         = mem_dout_q;
  assign bus.mem_wr           = mem_wr_q && rdy && !stall;
  assign bus.out_fetcher_flag = of_flag_q;
  assign bus.out_fetcher_data = of_data_q;
  assign bus.out_lsb_flag     = ol_flag_q;
  assign bus.out_lsb_data     = ol_data_q;
  assign bus.out_rob_flag     = or_flag_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed vectors for mem_ctrl with a behavioural byte RAM
// (one-cycle read latency, frozen together with the rest of the system by rdy).
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst, rdy;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_ctrl_if bus();

  mem_ctrl #(.IO_PORT_ADDR(32'h0003_0000)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  logic [7:0]  ram [logic [31:0]];
  logic [39:0] wlog [$];

  always @(posedge clk) begin
    if (bus.mem_wr) begin
      ram[bus.mem_a] = bus.mem_dout;
      wlog.push_back({bus.mem_a, bus.mem_dout});
    end
    if (rdy) bus.mem_din <= ram.exists(bus.mem_a) ? ram[bus.mem_a] : 8'h00;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    bus.in_fetcher_flag = 1'b0;
    bus.in_lsb_flag     = 1'b0;
    bus.in_rob_flag     = 1'b0;
    bus.in_rob_xbp      = 1'b0;
  endtask

  task automatic req_fetch(input logic [31:0] a);
    bus.in_fetcher_flag = 1'b1;
    bus.in_fetcher_addr = a;
  endtask

  task automatic req_load(input logic [31:0] a, input logic [5:0] sz, input logic sg);
    bus.in_lsb_flag   = 1'b1;
    bus.in_lsb_addr   = a;
    bus.in_lsb_size   = sz;
    bus.in_lsb_signed = sg;
  endtask

  task automatic req_store(input logic [31:0] a, input logic [5:0] sz, input logic [31:0] d);
    bus.in_rob_flag = 1'b1;
    bus.in_rob_addr = a;
    bus.in_rob_size = sz;
    bus.in_rob_data = d;
  endtask

  function automatic logic flag_of(input int sel);
    case (sel)
      0:       return bus.out_fetcher_flag;
      1:       return bus.out_lsb_flag;
      default: return bus.out_rob_flag;
    endcase
  endfunction

  // Count edges until the selected done flag shows; bounded at 30
  task automatic wait_done(input int sel, input int exp_lat, input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!flag_of(sel) && n < 30);
    check_eq({tag, "_latency"}, n, exp_lat);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_mem_a"},    bus.mem_a, 32'h0);
    check_eq({tag, "_mem_wr"},   {31'b0, bus.mem_wr}, 32'h0);
    check_eq({tag, "_mem_dout"}, {24'b0, bus.mem_dout}, 32'h0);
    check_eq({tag, "_flags"},    {29'b0, bus.out_fetcher_flag, bus.out_lsb_flag, bus.out_rob_flag}, 32'h0);
    check_eq({tag, "_f_data"},   bus.out_fetcher_data, 32'h0);
    check_eq({tag, "_l_data"},   bus.out_lsb_data, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_b [4];
    int t_rob, t_lsb, t_f, nf, nl;
    logic [31:0] d_lsb, d_f;

    exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
    ram[32'h200] = 8'h80; ram[32'h201] = 8'h7F; ram[32'h202] = 8'hC3;

    rst = 1'b1; rdy = 1'b1;
    clear_pulses();
    bus.in_fetcher_addr = '0; bus.in_lsb_addr = '0; bus.in_lsb_size = '0; bus.in_lsb_signed = 1'b0;
    bus.in_rob_addr = '0; bus.in_rob_size = '0; bus.in_rob_data = '0;
    bus.io_buffer_full = 1'b0;
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Fetch: 13 05 00 00 -> 0x00000513 after edge 5
    req_fetch(32'h100);
    tick();
    clear_pulses();
    check_eq("fetch_mem_a0", bus.mem_a, 32'h100);
    check_eq("fetch_mem_wr", {31'b0, bus.mem_wr}, 32'h0);
    wait_done(0, 5, "fetch");
    check_eq("fetch_data", bus.out_fetcher_data, 32'h0000_0513);
    tick();
    check_eq("fetch_pulse_width", {31'b0, bus.out_fetcher_flag}, 32'h0);

    // Byte/half loads with sign and zero extension
    req_load(32'h200, 6'd1, 1'b1);
    tick(); clear_pulses();
    wait_done(1, 2, "lb");
    check_eq("lb_data", bus.out_lsb_data, 32'hFFFF_FF80);
    tick();
    req_load(32'h200, 6'd1, 1'b0);
    tick(); clear_pulses();
    wait_done(1, 2, "lbu");
    check_eq("lbu_data", bus.out_lsb_data, 32'h0000_0080);
    tick();
    req_load(32'h201, 6'd2, 1'b1);
    tick(); clear_pulses();
    wait_done(1, 3, "lh");
    check_eq("lh_data", bus.out_lsb_data, 32'hFFFF_C37F);
    tick();

    // Simultaneous store, load, fetch: store first, then load, then fetch
    wlog.delete();
    req_store(32'h300, 6'd4, 32'hDEAD_BEEF);
    req_load(32'h301, 6'd2, 1'b1);
    req_fetch(32'h100);
    tick(); clear_pulses();
    t_rob = -1; t_lsb = -1; t_f = -1; d_lsb = '0; d_f = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.out_rob_flag && t_rob < 0) t_rob = k;
      if (bus.out_lsb_flag && t_lsb < 0) begin t_lsb = k; d_lsb = bus.out_lsb_data; end
      if (bus.out_fetcher_flag && t_f < 0) begin t_f = k; d_f = bus.out_fetcher_data; end
    end
    check_eq("arb_rob_edge", t_rob, 4);
    check_eq("arb_lsb_edge", t_lsb, 8);
    check_eq("arb_fetch_edge", t_f, 14);
    check_eq("arb_lsb_data", d_lsb, 32'hFFFF_ADBE);
    check_eq("arb_fetch_data", d_f, 32'h0000_0513);
    check_eq("sw_write_count", wlog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wlog.size())
        check_eq($sformatf("sw_byte%0d", i), wlog[i], {32'h300 + 32'(i), exp_b[i]});
    end

    // Flush while fetch reads byte 2: fetch and pending load dropped, store kept
    req_fetch(32'h100);
    tick(); clear_pulses();
    req_store(32'h310, 6'd1, 32'h0000_0055);
    req_load(32'h200, 6'd1, 1'b0);
    tick(); clear_pulses();
    tick();
    check_eq("flush_mem_a_byte2", bus.mem_a, 32'h102);
    bus.in_rob_xbp = 1'b1;
    tick(); clear_pulses();
    t_rob = -1; nf = 0; nl = 0;
    for (int k = 4; k <= 15; k++) begin
      tick();
      if (bus.out_rob_flag && t_rob < 0) t_rob = k;
      nf += int'(bus.out_fetcher_flag);
      nl += int'(bus.out_lsb_flag);
    end
    check_eq("flush_fetch_done_count", nf, 0);
    check_eq("flush_load_done_count", nl, 0);
    check_eq("flush_store_edge", t_rob, 5);
    check_eq("flush_store_ram", {24'b0, ram[32'h310]}, 32'h55);

    // Store to the I/O window while the output buffer is full
    wlog.delete();
    bus.io_buffer_full = 1'b1;
    req_store(32'h0003_0000, 6'd1, 32'h0000_0041);
    tick(); clear_pulses();
`ifdef MEM_CTRL_IO_STALL_EN
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("io_stall_wr%0d", i), {31'b0, bus.mem_wr}, 32'h0);
      tick();
    end
    bus.io_buffer_full = 1'b0;
    #1;
    check_eq("io_release_wr", {31'b0, bus.mem_wr}, 32'h1);
    check_eq("io_release_dout", {24'b0, bus.mem_dout}, 32'h41);
    wait_done(2, 1, "io_sb");
`else
    check_eq("io_nostall_wr", {31'b0, bus.mem_wr}, 32'h1);
    wait_done(2, 1, "io_sb");
    bus.io_buffer_full = 1'b0;
`endif
    check_eq("io_write_count", wlog.size(), 1);
    if (wlog.size() > 0) check_eq("io_write_entry", wlog[0], {32'h0003_0000, 8'h41});
    tick();

    // rdy low freezes a fetch and blocks mem_wr during a store
    req_fetch(32'h100);
    tick(); clear_pulses();
    tick();
    rdy = 1'b0;
    tick(); tick();
    check_eq("rdy_hold_mem_a", bus.mem_a, 32'h101);
    rdy = 1'b1;
    wait_done(0, 4, "rdy_fetch");
    check_eq("rdy_fetch_data", bus.out_fetcher_data, 32'h0000_0513);
    tick();
    req_store(32'h320, 6'd1, 32'h0000_0099);
    tick(); clear_pulses();
    check_eq("rdy_sb_wr_on", {31'b0, bus.mem_wr}, 32'h1);
    rdy = 1'b0;
    #1;
    check_eq("rdy_sb_wr_forced", {31'b0, bus.mem_wr}, 32'h0);
    tick();
    rdy = 1'b1;
    wait_done(2, 1, "rdy_sb");
    check_eq("rdy_sb_ram", {24'b0, ram[32'h320]}, 32'h99);
    tick();

    // Reset during an LW aborts it; a later fetch runs normally
    req_load(32'h100, 6'd4, 1'b0);
    tick(); clear_pulses();
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("midrst");
    nl = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      nl += int'(bus.out_lsb_flag);
    end
    check_eq("midrst_no_load_done", nl, 0);
    req_fetch(32'h100);
    tick(); clear_pulses();
    wait_done(0, 5, "post_rst_fetch");
    check_eq("post_rst_fetch_data", bus.out_fetcher_data, 32'h0000_0513);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller that owns the single byte-wide RAM port and shares it among three requesters: the instruction fetcher (word fetch), the LSB (loads) and the ROB (committed stores). It latches single-cycle request pulses, arbitrates by fixed priority, serialises each access into byte transfers, assembles or sign-extends the read data, and returns a one-cycle done pulse to the owning requester. A branch mispredict flushes speculative reads but never a committed store.

## Interface
Parameters:
- IO_PORT_ADDR, 32'h00030000, lowest address of the memory-mapped I/O window (window is IO_PORT_ADDR..IO_PORT_ADDR+7)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- in_fetcher_flag  in  1  fetch request pulse
- in_fetcher_addr  in  32  fetch address, always 4 bytes
- out_fetcher_flag  out  1  fetch done pulse
- out_fetcher_data  out  32  fetched instruction, little-endian
- in_lsb_flag  in  1  load request pulse
- in_lsb_addr  in  32  load address
- in_lsb_size  in  6  byte count: 1, 2 or 4
- in_lsb_signed  in  1  1 = sign-extend, 0 = zero-extend
- out_lsb_flag  out  1  load done pulse
- out_lsb_data  out  32  extended load result
- in_rob_flag  in  1  store request pulse
- in_rob_addr  in  32  store address
- in_rob_size  in  6  byte count: 1, 2 or 4
- in_rob_data  in  32  store data; low bytes used
- out_rob_flag  out  1  store done pulse
- in_rob_xbp  in  1  mispredict flush
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write, 0 = read
- io_buffer_full  in  1  I/O output buffer full

## Operation
- States: IDLE, READ, WRITE.
- Each source has one pending register (flag, addr, size, signed, data). A request pulse sets it. A pulse from a source whose request is already pending or in service is ignored.
- Arbitration in IDLE, over pending requests plus pulses sampled at the same edge. Priority: ROB store, then LSB load, then fetch.
- On accept: the pending entry clears and the counter is set to 0. State goes to READ (fetch/load) or WRITE (store).
- READ: mem_wr=0 and mem_a=base+i for bytes i=0..N-1. Byte i is captured into the assembly register one cycle later.
- Result formation: LB/LH take bit 7/15 as the sign when signed, else zero-fill. Fetch and LW take the raw 32 bits.
- WRITE: mem_wr=1, mem_a=base+i, mem_dout=data[8i+7:8i].
- Outside WRITE cycles, mem_wr=0.
- On completion: exactly one done flag is high for one cycle, the data output is valid in that same cycle, and the state returns to IDLE.
- Flush (rdy=1, in_rob_xbp=1): clears pending fetch and load. An in-service READ aborts to IDLE with no done pulse. An in-service WRITE and a pending store are unaffected.
- rdy=0: no state, counter or output changes, except that mem_wr is forced to 0.
- Reset values: state IDLE, all pending clear, mem_a=0, mem_dout=0, mem_wr=0, every out_*_flag=0, every out_*_data=0.

## Timing
- Accept happens at edge 0. Byte i is on mem_a during the cycle after edge i.
- READ: mem_din for byte i is valid the cycle after edge i+1 and is captured at edge i+2. The done flag is set at edge N+1.
  - LW and fetch: done visible after edge 5.
  - LB: done visible after edge 2.
- WRITE: the done flag is set at edge N, and mem_wr drops at that same edge.
  - SW: done after edge 4.
  - SB: done after edge 1.
- The completion edge returns to IDLE. The next accept is no earlier than the following edge, so there is one idle bus cycle between accesses.
- A request pulse arriving at a completion edge is latched into pending and served normally.
- A reset asserted mid-access aborts immediately with no done pulse; a partial store may remain in RAM.

## Configuration
- MEM_CTRL_IO_STALL_EN defined: a WRITE whose current byte address lies in the I/O window holds the counter and keeps mem_wr=0 while io_buffer_full=1. The byte is issued in the first cycle with io_buffer_full=0.
- Not defined: io_buffer_full is ignored and write timing is always N cycles.

## Structure
- Shared defines header holds: TRUE/FALSE, DATA_TYPE width, size encodings 1/2/4, RAM_IO_PORT, ZERO_WORD.
- One sub-module is natural: mem_ctrl_arb, a combinational fixed-priority selector over the three pending/pulse sources that returns a grant one-hot.

## Test plan
- Fetch at 0x00000100 (RAM bytes 13 05 00 00) -> out_fetcher_flag after edge 5, out_fetcher_data=0x00000513.
- LB signed at 0x200 (byte 0x80) -> out_lsb_data=0xFFFFFF80; the same access with LBU -> 0x00000080.
- ROB SW 0xDEADBEEF at 0x300, LSB load and fetch pulsed on the same edge:
  - store served first, with mem_dout sequence EF BE AD DE;
  - then the load, then the fetch;
  - one idle cycle between each access.
- Fetch in service at byte 2 when in_rob_xbp pulses -> no out_fetcher_flag, state IDLE; a store pending at that time completes afterwards.
- With MEM_CTRL_IO_STALL_EN, SB to 0x30000 while io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for those cycles, then one write of the byte, then out_rob_flag.
- rst high for one edge during an LW -> all outputs return to reset values, no done pulse, and the next fetch is accepted normally.
